// File: rtl/register_pipe_pkg.sv
// Shared defaults and sizing helpers for the register_pipe valid-tagged delay line.
package register_pipe_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_RESET_VAL = 0;

  // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One data+valid stage: data moves on en, valid is cleared by flush with priority.
module pipe_stage
  import register_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q         <= RESET_VAL;
      out_valid <= 1'b0;
    end else begin
      if (en) begin
        q <= d;
      end
      // Data still follows en during a flush; only the tag is killed.
      if (flush) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= in_valid;
      end
    end
  end

endmodule

// File: rtl/register_pipe.sv
// Enable-gated register pipeline of DEPTH pipe_stage instances with flush and a registered occupancy count.
module register_pipe
  import register_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              d,
  output logic [WIDTH-1:0]              q,
  output logic                          out_valid,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(DEPTH);

  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] valid_next;
  logic [OCC_W-1:0] occ_next;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .d         (d),
        .out_valid (valid_vec[g]),
        .q         (stage_data[g])
      );
    end else begin : g_body
      pipe_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_valid  (valid_vec[g-1]),
        .d         (stage_data[g-1]),
        .out_valid (valid_vec[g]),
        .q         (stage_data[g])
      );
    end
  end

  // Predict the valid vector the stages will hold after this edge so the
  // count lands on the same edge as the flags themselves.
  always_comb begin
    valid_next = valid_vec;
    if (flush) begin
      valid_next = '0;
    end else if (en) begin
      valid_next[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_next[i] = valid_vec[i-1];
      end
    end
    occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(valid_next[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

  assign q         = stage_data[DEPTH-1];
  assign out_valid = valid_vec[DEPTH-1];

endmodule

// File: tb/tb_register_pipe.sv
// Scoreboard bench for register_pipe: a slot-array reference model pushes expected outputs, a negedge monitor compares.
module tb_register_pipe;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         out_valid;
  logic [2:0]   occupancy;

  register_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .d         (d),
    .q         (q),
    .out_valid (out_valid),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic         ov;
    logic [2:0]   occ;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: D slots of (valid, data); slot D-1 is the output.
  logic [W-1:0] m_d [D];
  logic         m_v [D];
  string        phase = "init";

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_d[i] = 8'h00;
      m_v[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m_v[i]);
    return c;
  endfunction

  task automatic step(input logic e, input logic f, input logic iv, input logic [W-1:0] dd);
    exp_t x;
    en = e; flush = f; in_valid = iv; d = dd;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (e) begin
        for (int i = D-1; i > 0; i--) begin
          m_d[i] = m_d[i-1];
          m_v[i] = m_v[i-1];
        end
        m_d[0] = dd;
        m_v[0] = iv;
      end
      if (f) begin
        for (int i = 0; i < D; i++) m_v[i] = 1'b0;
      end
    end
    x.q   = m_d[D-1];
    x.ov  = m_v[D-1];
    x.occ = 3'(model_count());
    x.tag = phase;
    exp_q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_tests++;
      if (q !== cur.q || out_valid !== cur.ov || occupancy !== cur.occ) begin
        n_fail++;
        $display("FAIL %s @%0t: got q=%h out_valid=%b occ=%0d, want q=%h out_valid=%b occ=%0d",
                 cur.tag, $time, q, out_valid, occupancy, cur.q, cur.ov, cur.occ);
      end
    end
  end

  task automatic check_now(input string tag);
    n_tests++;
    if (q !== 8'h00 || out_valid !== 1'b0 || occupancy !== 3'd0) begin
      n_fail++;
      $display("FAIL %s: got q=%h out_valid=%b occ=%0d, want q=00 out_valid=0 occ=0",
               tag, q, out_valid, occupancy);
    end
  endtask

  // Async assert between edges, check immediately, hold one edge with junk inputs, release.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_now(tag);
    step(1'b1, 1'b0, 1'b1, 8'hEE);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; in_valid = 1'b0; d = '0;
    model_clear();
    #1;
    check_now("reset_state");
    @(negedge clk);
    #1;
    rst = 1'b0;

    phase = "stream";
    step(1, 0, 1, 8'h11);
    step(1, 0, 1, 8'h22);
    step(1, 0, 1, 8'h33);
    step(1, 0, 1, 8'h44);
    step(1, 0, 1, 8'h55);

    do_reset("async_reset_full");

    phase = "stall";
    step(1, 0, 1, 8'h11);
    step(1, 0, 1, 8'h22);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hFF);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00);

    do_reset("async_reset_stall");

    phase = "bubbles";
    for (int i = 0; i < 4; i++) step(1, 0, ~i[0], 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00);

    do_reset("async_reset_bubbles");

    phase = "flush";
    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'hC0 + 8'(i));
    step(1, 1, 1, 8'h99);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h12);

    do_reset("async_reset_flush");

    phase = "midreset";
    step(1, 0, 1, 8'h11);
    step(1, 0, 1, 8'h22);
    step(1, 0, 1, 8'h33);
    do_reset("async_reset_midstream");
    phase = "midreset";
    step(1, 0, 1, 8'h77);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00);

    phase = "random";
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), 8'($urandom));
    end
    rst = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_pipe.md
REGISTER_PIPE -- requirements
Module: register_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  advance enable; 1 shifts the pipe, 0 holds every stage.
REQ-007 flush  input  1  synchronous clear of all valid flags.
REQ-008 in_valid  input  1  qualifies d.
REQ-009 d  input  WIDTH  data into stage 0.
REQ-010 q  output  WIDTH  data of stage DEPTH-1.
REQ-011 out_valid  output  1  valid flag of stage DEPTH-1.
REQ-012 occupancy  output  $clog2(DEPTH+1)  registered count of valid stages, 0..DEPTH.

Function
REQ-013 Rising edge, en=1, flush=0: stage[0] <= d, valid[0] <= in_valid; stage[i] <= stage[i-1], valid[i] <= valid[i-1] for i=1..DEPTH-1.
REQ-014 Rising edge, en=0, flush=0: all data and valid registers hold; d and in_valid ignored.
REQ-015 Latency: a word presented with en=1 appears on q/out_valid exactly DEPTH enabled edges later; stalled cycles add no data loss.
REQ-016 Data registers shift when en=1 regardless of in_valid; invalid words travel as bubbles.
REQ-017 flush=1 at a rising edge: every valid flag, including the one that en would load from in_valid, becomes 0; data registers follow REQ-013/REQ-014 per en.
REQ-018 flush has priority over en and in_valid in every combination.
REQ-019 occupancy equals popcount of the valid vector after each edge (registered, same edge as the valid flags), never exceeds DEPTH, no wrap.
REQ-020 q and out_valid are driven directly from stage DEPTH-1 registers; no combinational path from any input to any output.
REQ-021 DEPTH=1 degenerates to one enabled register with valid flag; q follows d one enabled edge later.

Reset
REQ-022 rst=1 forces immediately, independent of clk: all data stages = RESET_VAL, all valid = 0, q = RESET_VAL, out_valid = 0, occupancy = 0.
REQ-023 rst asserted mid-stream discards all in-flight words; first enabled edge after rst deasserts loads stage 0 normally.
REQ-024 While rst=1, en, flush, in_valid and d have no effect.

Structure
REQ-025 Shared package register_pipe_pkg holds default WIDTH/DEPTH/RESET_VAL constants and an occupancy-width function (clog2 of DEPTH+1).
REQ-026 One sub-module pipe_stage (WIDTH data + 1 valid bit, en, flush, async rst) instantiated DEPTH times via generate; occupancy counter lives in register_pipe.

Verification (WIDTH=8, DEPTH=4, RESET_VAL=0)
REQ-027 Reset: rst=1 asynchronously between edges with pipe full -> q=0x00, out_valid=0, occupancy=0 before the next edge.
REQ-028 Streaming: en=1, in_valid=1, d=0x11,0x22,0x33,0x44,0x55 on consecutive edges -> q=0x11 with out_valid=1 after edge 4, 0x22 after edge 5; occupancy 1,2,3,4,4.
REQ-029 Stall: after loading 0x11,0x22, hold en=0 for 3 edges with d=0xFF -> all stages and occupancy=2 unchanged; resume en=1 and 0x11 reaches q 2 enabled edges later, 0xFF never captured.
REQ-030 Bubbles: in_valid pattern 1,0,1,0 with d=0xA0..0xA3 -> out_valid sequence 1,0,1,0 from edge 4; occupancy peaks at 2.
REQ-031 Flush: pipe full (occupancy=4), flush=1 with en=1, in_valid=1, d=0x99 -> next edge out_valid=0, occupancy=0; 0x99 is in stage 0 but marked invalid.
REQ-032 Mid-stream reset: rst pulse during streaming of 0x11..0x44 -> outputs cleared immediately; after release, new word 0x77 emerges on q exactly 4 enabled edges later with out_valid=1.
